gray_sequence_decoder: RTL and testbench
========================================

Name: gray_sequence_decoder

Overview:
- Receive end of the team's Gray-code counter sequence (00,01,11,10 for 2 bits).
- Samples a Gray-coded input each qualified cycle and decodes it to binary.
- Classifies each transition as up-step, down-step, hold or illegal, and keeps a signed-free position count plus an error count.
- Used to check and track Gray counter outputs and quadrature-style 2-bit sources.

Parameters:
W, 2, Gray code width; legal range 2..8
POS_W, 16, width of position counter
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
g_in  input  W  Gray-coded sample
g_valid  input  1  g_in qualified this cycle
clr  input  1  synchronous clear of counters and lock state
bin_out  output  W  registered binary decode of last accepted sample
step_up  output  1  one-cycle pulse, legal +1 transition
step_dn  output  1  one-cycle pulse, legal -1 transition
step_err  output  1  one-cycle pulse, illegal transition
dir  output  1  last legal direction, 1=up 0=down
pos  output  POS_W  position count, modulo 2^POS_W
err_cnt  output  ERR_W  illegal-transition count, saturating at all-ones
locked  output  1  high in TRACK state

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; bin_out=0, step_up=step_dn=step_err=0, dir=1, pos=0, err_cnt=0, locked=0.
- Decode: bin[W-1]=g[W-1]; bin[i]=bin[i+1] XOR g[i]. This is combinational on g_in and registered into bin_out.
- delta = (bin_new - bin_prev) mod 2^W, where bin_prev is the bin_out register.
- Outputs are registered: results appear 1 cycle after the g_valid cycle. Pulses last exactly 1 cycle; with no g_valid, all pulses are 0.
- States:
  - IDLE: first g_valid captures bin_out and moves to TRACK. No pulse; pos unchanged.
  - TRACK, on g_valid:
    - delta=0: hold. No pulse; bin_out reloaded with the same value.
    - delta=1: step_up=1, pos+1, dir=1.
    - delta=2^W-1: step_dn=1, pos-1, dir=0.
    - Any other delta: step_err=1, err_cnt+1 (saturating), pos and dir unchanged, bin_out unchanged, go to FAULT.
  - FAULT: locked=0. The next g_valid recaptures bin_out with no pulse and moves to TRACK.
- pos wraps: max+1 gives 0; 0-1 gives all-ones.
- err_cnt at all-ones stays all-ones; step_err still pulses.
- bin_out wraps naturally. For W=2, 11 (Gray 10) to 00 (Gray 00) is a legal up-step.
- clr high: pos=0, err_cnt=0, pulses=0, state=IDLE, locked=0; bin_out and dir keep their values.
  - clr has priority over a simultaneous g_valid, and that sample is discarded.
- rst low mid-operation forces the reset values immediately, regardless of clk.
- g_in is assumed synchronous to clk. No internal synchronizer.

Test Plan:
- Reset, then g_valid with Gray 00,01,11,10,00 on consecutive cycles (W=2):
  - First sample: locked=1, no pulse.
  - Next four samples: step_up each, pos=4, bin_out 1,2,3,0, dir=1.
- From pos=4, bin_out=0, feed Gray 10,11,01:
  - Three step_dn pulses, pos=1, dir=0.
- In TRACK with bin_out=0 (Gray 00), feed Gray 11 (binary 2):
  - step_err=1, err_cnt=1, locked=0, pos unchanged.
  - Next Gray 01 relocks with no pulse; the following Gray 11 gives step_up.
- Force 300 illegal transitions (W=2, ERR_W=8), alternating Gray 00/11 with relock samples between:
  - err_cnt saturates at 255; step_err still pulses.
- pos=0 then one down-step:
  - pos=65535.
  - Assert clr together with g_valid: pos=0, err_cnt=0, locked=0, no pulse.
- Drop rst asynchronously between clock edges mid-sequence:
  - All outputs go to reset values before the next edge.
  - After release, the first sample only locks.

Source files
------------

// File: rtl/gray_sequence_decoder.sv
// Gray-code sequence decoder: decodes each qualified Gray sample to binary and
// classifies the transition as up-step, down-step, hold or illegal, with
// position and saturating error counters.
module gray_sequence_decoder #(
  parameter int W     = 2,
  parameter int POS_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     g_in,
  input  logic             g_valid,
  input  logic             clr,
  output logic [W-1:0]     bin_out,
  output logic             step_up,
  output logic             step_dn,
  output logic             step_err,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [W-1:0] DELTA_HOLD = '0;
  localparam logic [W-1:0] DELTA_UP   = W'(1);
  localparam logic [W-1:0] DELTA_DN   = '1;

  state_t     state;
  logic [W-1:0] bin_dec;
  logic [W-1:0] delta;
  logic         err_full;

  // Each binary bit is the XOR of all Gray bits at or above it; computed per
  // bit so there is no combinational chain through bin_dec itself.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_decode
      assign bin_dec[gi] = ^g_in[W-1:gi];
    end
  endgenerate

  assign delta    = bin_dec - bin_out;
  assign err_full = &err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bin_out  <= '0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      step_err <= 1'b0;
      dir      <= 1'b1;
      pos      <= '0;
      err_cnt  <= '0;
      locked   <= 1'b0;
    end else begin
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      step_err <= 1'b0;
      if (clr) begin
        // A sample arriving together with clr is discarded.
        pos     <= '0;
        err_cnt <= '0;
        state   <= IDLE;
        locked  <= 1'b0;
      end else if (g_valid) begin
        case (state)
          IDLE, FAULT: begin
            bin_out <= bin_dec;
            state   <= TRACK;
            locked  <= 1'b1;
          end
          TRACK: begin
            if (delta == DELTA_HOLD) begin
              bin_out <= bin_dec;
            end else if (delta == DELTA_UP) begin
              bin_out <= bin_dec;
              step_up <= 1'b1;
              pos     <= pos + POS_W'(1);
              dir     <= 1'b1;
            end else if (delta == DELTA_DN) begin
              bin_out <= bin_dec;
              step_dn <= 1'b1;
              pos     <= pos - POS_W'(1);
              dir     <= 1'b0;
            end else begin
              // Illegal jump: keep the last good position, wait for relock.
              step_err <= 1'b1;
              if (!err_full) begin
                err_cnt <= err_cnt + ERR_W'(1);
              end
              state  <= FAULT;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_sequence_decoder.sv
// Directed bench for gray_sequence_decoder (W=2): a behavioural model pushes
// expected outputs to a queue as each sample is driven; they are popped after the edge.
module tb_gray_sequence_decoder;

  localparam int W     = 2;
  localparam int POS_W = 16;
  localparam int ERR_W = 8;

  typedef struct packed {
    logic [W-1:0]     bin;
    logic             up;
    logic             dn;
    logic             er;
    logic             dir;
    logic [POS_W-1:0] pos;
    logic [ERR_W-1:0] errc;
    logic             locked;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [W-1:0]     g_in;
  logic             g_valid;
  logic             clr;
  logic [W-1:0]     bin_out;
  logic             step_up;
  logic             step_dn;
  logic             step_err;
  logic             dir;
  logic [POS_W-1:0] pos;
  logic [ERR_W-1:0] err_cnt;
  logic             locked;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t m;
  int   m_state;  // 0 idle, 1 track, 2 fault

  gray_sequence_decoder #(.W(W), .POS_W(POS_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .g_in(g_in), .g_valid(g_valid), .clr(clr),
    .bin_out(bin_out), .step_up(step_up), .step_dn(step_dn), .step_err(step_err),
    .dir(dir), .pos(pos), .err_cnt(err_cnt), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("bin_out",  32'(bin_out),  32'(e.bin));
    chk("step_up",  32'(step_up),  32'(e.up));
    chk("step_dn",  32'(step_dn),  32'(e.dn));
    chk("step_err", 32'(step_err), 32'(e.er));
    chk("dir",      32'(dir),      32'(e.dir));
    chk("pos",      32'(pos),      32'(e.pos));
    chk("err_cnt",  32'(err_cnt),  32'(e.errc));
    chk("locked",   32'(locked),   32'(e.locked));
  endtask

  function automatic int gray2bin(input int g);
    int b = 0;
    for (int i = 0; i < W; i++) b = b ^ (g >> i);
    return b & ((1 << W) - 1);
  endfunction

  task automatic model_reset();
    m        = '0;
    m.dir    = 1'b1;
    m_state  = 0;
  endtask

  task automatic model_update(input logic gv, input logic [W-1:0] g, input logic c);
    int b;
    int d;
    m.up = 1'b0;
    m.dn = 1'b0;
    m.er = 1'b0;
    if (c) begin
      m.pos    = '0;
      m.errc   = '0;
      m_state  = 0;
      m.locked = 1'b0;
    end else if (gv) begin
      b = gray2bin(int'(g));
      if (m_state != 1) begin
        m.bin    = W'(b);
        m_state  = 1;
        m.locked = 1'b1;
      end else begin
        d = (b - int'(m.bin)) & ((1 << W) - 1);
        if (d == 0) begin
          m.bin = W'(b);
        end else if (d == 1) begin
          m.bin = W'(b); m.up = 1'b1; m.pos = m.pos + 1'b1; m.dir = 1'b1;
        end else if (d == (1 << W) - 1) begin
          m.bin = W'(b); m.dn = 1'b1; m.pos = m.pos - 1'b1; m.dir = 1'b0;
        end else begin
          m.er = 1'b1;
          if (m.errc != '1) m.errc = m.errc + 1'b1;
          m_state  = 2;
          m.locked = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input logic gv, input logic [W-1:0] g, input logic c);
    exp_t e;
    @(negedge clk);
    g_valid = gv;
    g_in    = g;
    clr     = c;
    model_update(gv, g, c);
    sb.push_back(m);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      check_all(e);
    end
    g_valid = 1'b0;
    clr     = 1'b0;
  endtask

  initial begin
    rst = 1'b0; g_in = '0; g_valid = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all(m);
    @(negedge clk);
    rst = 1'b1;

    // Up sequence 00,01,11,10,00
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    chk("pos_after_up", 32'(pos), 32'd4);
    step(1'b0, 2'b01, 1'b0);

    // Down sequence 10,11,01
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    chk("pos_after_dn", 32'(pos), 32'd1);
    chk("dir_after_dn", 32'(dir), 32'd0);

    // Back to bin 0, then illegal jump, relock, up-step, hold
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    chk("err_first", 32'(err_cnt), 32'd1);
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b11, 1'b0);

    // 300 illegal jumps (bin 2 -> bin 0), each followed by a relock at Gray 11
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 2'b00, 1'b0);
      step(1'b1, 2'b11, 1'b0);
    end
    chk("err_saturated", 32'(err_cnt), 32'd255);
    step(1'b1, 2'b00, 1'b0);

    // Clear, lock, down-step from 0 wraps to all-ones
    step(1'b0, 2'b00, 1'b1);
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    chk("pos_wrap", 32'(pos), 32'd65535);
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b10, 1'b1);
    step(1'b1, 2'b10, 1'b0);

    // Asynchronous reset between edges
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all(m);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b10, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
